// File: rtl/melody_ram_fm_tx.sv
// Programmable-melody FM transmitter: note RAM, sequencer FSM, square-wave carrier.
// Optional feature macro GLIDE_EN: smooth portamento between note increments.
module melody_ram_fm_tx #(
  parameter int                    ACC_WIDTH   = 32,
  parameter int                    DEPTH       = 32,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [31:0]           TICK_DIV    = 32'd6_250_000,
  parameter logic [ACC_WIDTH-1:0]  BASE_INC    = 32'h40000000,
  parameter logic [ACC_WIDTH-1:0]  DEV_STEP    = 32'h00418937,
  parameter int                    GLIDE_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  loop,
  input  logic                  start,
  input  logic [31:0]           tempo_div,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  wr_err,
  output logic                  fm_out,
  output logic [ACC_WIDTH-1:0]  phase_inc_out,
  output logic                  playing,
  output logic                  melody_end,
  output logic [ADDR_WIDTH-1:0] note_index
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           tempo_q, tempo_d;
  logic [31:0]           tick_q, tick_d;
  logic [3:0]            six_q, six_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  inc_q, inc_d;
  logic                  wr_err_q;
  logic                  mend;

  logic [15:0]           mem [DEPTH];
  logic [15:2]           note_q;

  logic [7:0]            pitch;
  logic [3:0]            dur;
  logic                  rest;
  logic                  endb;
  logic [ACC_WIDTH-1:0]  pext;
  logic [ACC_WIDTH-1:0]  target;
  logic [ACC_WIDTH-1:0]  inc_next;
  logic                  tick_wrap;
  logic                  expire;
  logic                  last;

  // Note RAM: writes only while idle; registered read in FETCH
  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
    if (state_q == FETCH) begin
      note_q <= mem[addr_q][15:2];
    end
  end

  assign pitch  = note_q[15:8];
  assign dur    = note_q[7:4];
  assign rest   = note_q[3];
  assign endb   = note_q[2];
  assign pext   = {{(ACC_WIDTH-8){pitch[7]}}, pitch};
  assign target = BASE_INC + pext * DEV_STEP;

`ifdef GLIDE_EN
  logic [ACC_WIDTH-1:0] diff;
  logic [ACC_WIDTH-1:0] mag;
  logic [ACC_WIDTH-1:0] step;

  always_comb begin
    diff = target - inc_q;
    mag  = diff[ACC_WIDTH-1] ? (~diff + 1'b1) : diff;
    step = ACC_WIDTH'($signed(diff) >>> GLIDE_SHIFT);
    if (mag < (ACC_WIDTH'(1) << GLIDE_SHIFT)) begin
      inc_next = target;
    end else begin
      inc_next = inc_q + step;
    end
  end

  assign phase_inc_out = inc_q;
`else
  assign inc_next      = target;
  assign phase_inc_out = (state_q == PLAY) ? target : inc_q;
`endif

  assign tick_wrap = (tick_q == tempo_q - 32'd1);
  assign expire    = (state_q == PLAY) && tick_wrap && (six_q == dur);
  assign last      = endb || (addr_q == ADDR_WIDTH'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tempo_d = tempo_q;
    tick_d  = tick_q;
    six_d   = six_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    mend    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d = '0;
          if (start) begin
            state_d = FETCH;
            addr_d  = '0;
            tempo_d = (tempo_div == 32'd0) ? TICK_DIV : tempo_div;
          end
        end
        FETCH: begin
          acc_d   = acc_q + inc_q;
          tick_d  = '0;
          six_d   = '0;
          state_d = PLAY;
        end
        PLAY: begin
          inc_d = inc_next;
          if (!rest) begin
            acc_d = acc_q + phase_inc_out;
          end
          if (tick_wrap) begin
            tick_d = '0;
            six_d  = six_q + 4'd1;
          end else begin
            tick_d = tick_q + 32'd1;
          end
          if (expire) begin
            if (last) begin
              mend = 1'b1;
              if (loop) begin
                addr_d  = '0;
                state_d = FETCH;
              end else begin
                state_d = IDLE;
              end
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tempo_q  <= TICK_DIV;
      tick_q   <= '0;
      six_q    <= '0;
      acc_q    <= '0;
      inc_q    <= BASE_INC;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tempo_q  <= tempo_d;
      tick_q   <= tick_d;
      six_q    <= six_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      wr_err_q <= wr_en && (state_q != IDLE);
    end
  end

  assign wr_err     = wr_err_q;
  assign playing    = (state_q != IDLE);
  assign note_index = addr_q;
  assign melody_end = mend;
  assign fm_out     = acc_q[ACC_WIDTH-1] &&
                      ((state_q == FETCH) || (state_q == PLAY && !rest));

endmodule

// File: tb/tb_melody_ram_fm_tx.sv
// Bench for melody_ram_fm_tx: table vectors, directed corners, random melodies
// checked against a note-level timing model.
module tb_melody_ram_fm_tx;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam int          TDEF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tempo_div = 32'd0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_err;
  logic        fm_out;
  logic [31:0] phase_inc_out;
  logic        playing;
  logic        melody_end;
  logic [4:0]  note_index;

  melody_ram_fm_tx #(.TICK_DIV(32'd4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .loop(loop),
    .start(start), .tempo_div(tempo_div),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .fm_out(fm_out),
    .phase_inc_out(phase_inc_out), .playing(playing),
    .melody_end(melody_end), .note_index(note_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  int ntests = 0;
  int nfail  = 0;
  logic [15:0] mem [32];
  logic fmlog [64];

  typedef struct {
    bit          play;
    int          idx;
    bit          incv;
    logic [31:0] inc;
    bit          mend;
    bit          fmz;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int          pitch;
    int          dur;
    bit          rest;
    logic [31:0] tdiv;
    logic [31:0] einc;
    int          elen;
  } vec_t;
  vec_t vt[6];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] nw(int p, int d, bit r, bit e);
    logic [7:0] pb;
    logic [3:0] db;
    pb = 8'(p);
    db = 4'(d);
    return {pb, db, r, e, 2'b00};
  endfunction

  function automatic logic [31:0] tgt(logic [15:0] w);
    longint p;
    longint s;
    p = longint'($signed(w[15:8]));
    s = 64'h40000000 + p * 64'h418937;
    return s[31:0];
  endfunction

  task automatic wr(int a, logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_err_idle", 32'(wr_err), 32'd0);
    mem[a] = d;
  endtask

  // Expected per-cycle trace: 1 fetch cycle then (dur+1)*T play cycles per note
  task automatic build(int t, bit lp, int maxlen);
    int          i;
    int          len;
    bit          done;
    bit          lst;
    logic [15:0] w;
    exp_t        r;
    i    = 0;
    done = 1'b0;
    q.delete();
    while (!done && q.size() < maxlen) begin
      w   = mem[i];
      len = (int'(w[7:4]) + 1) * t;
      lst = w[2] || (i == 31);
      r = '{1'b1, i, 1'b0, 32'd0, 1'b0, 1'b0};
      q.push_back(r);
      for (int c = 0; c < len; c++) begin
        r = '{1'b1, i, 1'b1, tgt(w), lst && (c == len - 1), w[3]};
        q.push_back(r);
      end
      if (lst) begin
        if (lp) i = 0;
        else done = 1'b1;
      end else begin
        i++;
      end
    end
    if (done) begin
      repeat (3) begin
        r = '{1'b0, 0, 1'b0, 32'd0, 1'b0, 1'b1};
        q.push_back(r);
      end
    end
  endtask

  task automatic play(logic [31:0] td, bit lp, int maxlen,
                      int wr_at, int ab_at, int rs_at);
    int t;
    t = (td == 32'd0) ? TDEF : int'(td);
    build(t, lp, maxlen);
    tempo_div = td;
    loop      = lp;
    start     = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (k > 0 && k - 1 == ab_at) begin
        chk("abort_playing", 32'(playing), 32'd0);
        chk("abort_fm", 32'(fm_out), 32'd0);
        chk("abort_mend", 32'(melody_end), 32'd0);
        enable = 1'b1;
        break;
      end
      if (k > 0 && k - 1 == rs_at) begin
        chk("rst_inc", phase_inc_out, BASE);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_fm", 32'(fm_out), 32'd0);
        chk("rst_index", 32'(note_index), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        rst = 1'b0;
        break;
      end
      if (k < 64) fmlog[k] = fm_out;
      chk("playing", 32'(playing), 32'(q[k].play));
      if (q[k].play) chk("note_index", 32'(note_index), 32'(q[k].idx));
`ifndef GLIDE_EN
      if (q[k].incv) chk("phase_inc", phase_inc_out, q[k].inc);
`endif
      chk("melody_end", 32'(melody_end), 32'(q[k].mend));
      if (q[k].fmz) chk("fm_silent", 32'(fm_out), 32'd0);
      chk("wr_err", 32'(wr_err), 32'(k > 0 && k - 1 == wr_at));
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = ~mem[1];
      end
      if (k == ab_at) enable = 1'b0;
      if (k == rs_at) rst = 1'b1;
    end
    loop = 1'b0;
    if (playing) begin
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      chk("stop_playing", 32'(playing), 32'd0);
    end
  endtask

  task automatic load_basic();
    wr(0, nw(0, 0, 1'b0, 1'b0));
    wr(1, nw(2, 1, 1'b0, 1'b0));
    wr(2, nw(0, 0, 1'b1, 1'b1));
  endtask

  initial begin
    vt[0] = '{0,    0,  1'b0, 32'd0, 32'h40000000, 4};
    vt[1] = '{2,    1,  1'b0, 32'd0, 32'h4083126E, 8};
    vt[2] = '{-1,   2,  1'b0, 32'd3, 32'h3FBE76C9, 9};
    vt[3] = '{12,   0,  1'b0, 32'd5, 32'h43126E94, 5};
    vt[4] = '{127,  15, 1'b0, 32'd1, 32'h60831249, 16};
    vt[5] = '{-128, 3,  1'b1, 32'd2, 32'h1F3B6480, 8};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_inc", phase_inc_out, BASE);
    chk("reset_playing", 32'(playing), 32'd0);
    chk("reset_fm", 32'(fm_out), 32'd0);
    chk("reset_mend", 32'(melody_end), 32'd0);
    chk("reset_index", 32'(note_index), 32'd0);
    chk("reset_wr_err", 32'(wr_err), 32'd0);

    // basic three-note melody; fresh accumulator gives a quarter-turn waveform
    load_basic();
    play(32'd0, 1'b0, 1000, -1, -1, -1);
    chk("fm_wave", {28'd0, fmlog[1], fmlog[2], fmlog[3], fmlog[4]}, 32'b0110);
    chk("idle_inc_hold", phase_inc_out, tgt(mem[2]));

    // looping for two passes
    play(32'd0, 1'b1, 45, -1, -1, -1);

    // rejected write, then replay sees original note 1
    play(32'd0, 1'b0, 1000, 3, -1, -1);
    play(32'd0, 1'b0, 1000, -1, -1, -1);

    // abort mid-note 1 and reset mid-play
    play(32'd0, 1'b0, 1000, -1, 8, -1);
    play(32'd0, 1'b0, 1000, -1, -1, 10);
    @(negedge clk);

    // single-note table; the note is written in the same cycle as start
    for (int v = 0; v < 6; v++) begin
      int          len;
      logic [31:0] first;
      bit          loud;
      wr_en     = 1'b1;
      wr_addr   = 5'd0;
      wr_data   = nw(vt[v].pitch, vt[v].dur, vt[v].rest, 1'b1);
      mem[0]    = wr_data;
      tempo_div = vt[v].tdiv;
      start     = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      chk("tbl_fetch", 32'(playing), 32'd1);
      len   = 0;
      first = 32'd0;
      loud  = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (!playing) break;
        if (len == 0) first = phase_inc_out;
        if (fm_out) loud = 1'b1;
        len++;
      end
`ifndef GLIDE_EN
      chk("tbl_inc", first, vt[v].einc);
`endif
      chk("tbl_len", 32'(len), 32'(vt[v].elen));
      if (vt[v].rest) chk("tbl_rest_fm", 32'(loud), 32'd0);
    end

    // random melodies; last pass has no end bit and stops at the final address
    for (int it = 0; it < 5; it++) begin
      int n;
      n = (it == 4) ? 99 : int'($urandom_range(1, 8));
      for (int i = 0; i < 32; i++) begin
        wr(i, nw(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, i == n - 1));
      end
      play(32'($urandom_range(0, 3)), 1'b0, 4000, -1, -1, -1);
    end

`ifdef GLIDE_EN
    begin
      logic [31:0] prev;
      logic [31:0] gt;
      wr(0, nw(0, 0, 1'b0, 1'b0));
      wr(1, nw(12, 15, 1'b0, 1'b1));
      gt        = tgt(mem[1]);
      prev      = BASE;
      tempo_div = 32'd20;
      start     = 1'b1;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (!playing) break;
        if (note_index == 5'd1) begin
          chk("glide_mono", 32'(phase_inc_out >= prev), 32'd1);
          chk("glide_over", 32'(phase_inc_out <= gt), 32'd1);
          prev = phase_inc_out;
        end
      end
      chk("glide_final", prev, gt);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
